// File: rtl/ysyx_23060191_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   CPU_WIDTH       address/data width
//   NOP_INST        instruction substituted when a fetch faults
//   FAULT_*         inst_fault encodings
//   ST_*            fetch FSM state encoding (2 bits)
package ysyx_23060191_ifu_pkg;

  localparam int unsigned CPU_WIDTH = 32;

  localparam logic [CPU_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ACCESS   = 2'b10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  function automatic logic is_aligned(input logic [CPU_WIDTH-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060191_ifu_reg.sv
// Generic holding register with write enable and asynchronous active-low reset.
//   clk, rstn   clock / reset
//   wen         load din on the next rising edge
//   din, dout   data in / registered data out (RESET_VAL while in reset)
module ysyx_23060191_ifu_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_23060191_ifu.sv
// Instruction fetch unit: accepts a PC from the PC unit, performs one read on the
// AR/R instruction-memory channels and holds the result for the decoder.
//   clk, rstn                 clock / asynchronous active-low reset
//   pc_in, pc_valid, pc_ready fetch request from the PC unit
//   flush                     redirect: discard the in-flight or held fetch
//   araddr, arvalid, arready  read address channel
//   rdata, rresp, rvalid, rready  read data channel
//   inst, inst_pc, inst_fault, inst_valid, inst_ready  result to the decoder
module ysyx_23060191_ifu
  import ysyx_23060191_ifu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [CPU_WIDTH-1:0] pc_in,
  input  logic                 pc_valid,
  output logic                 pc_ready,
  input  logic                 flush,
  output logic [CPU_WIDTH-1:0] araddr,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [CPU_WIDTH-1:0] rdata,
  input  logic [1:0]           rresp,
  input  logic                 rvalid,
  output logic                 rready,
  output logic [CPU_WIDTH-1:0] inst,
  output logic [CPU_WIDTH-1:0] inst_pc,
  output logic [1:0]           inst_fault,
  output logic                 inst_valid,
  input  logic                 inst_ready
);

  logic [1:0]           state_q, state_d;
  logic                 drop_q, drop_d;
  logic                 pc_wen;
  logic                 inst_wen;
  logic [CPU_WIDTH-1:0] pc_q;
  logic [CPU_WIDTH-1:0] inst_d, inst_q;
  logic [CPU_WIDTH-1:0] inst_pc_d, inst_pc_q;
  logic [1:0]           fault_d, fault_q;

  // Handshakes only depend on registered state; pc_ready additionally masks flush.
  assign pc_ready   = (state_q == ST_IDLE) && !flush;
  assign arvalid    = (state_q == ST_REQ);
  assign rready     = (state_q == ST_WAIT);
  assign inst_valid = (state_q == ST_HOLD);
  assign araddr     = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = fault_q;

  assign pc_wen = (state_q == ST_IDLE) && pc_valid && !flush;

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    inst_wen  = 1'b0;
    inst_d    = NOP_INST;
    fault_d   = FAULT_NONE;
    inst_pc_d = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (pc_valid && !flush) begin
          if (!is_aligned(pc_in)) begin
            // Misaligned fetch never touches the bus.
            state_d   = ST_HOLD;
            inst_wen  = 1'b1;
            fault_d   = FAULT_MISALIGN;
            inst_pc_d = pc_in;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // The address phase cannot be withdrawn; remember to discard the response.
        if (flush) drop_d = 1'b1;
        if (arready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rvalid) begin
          if (drop_q || flush) begin
            state_d = ST_IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d  = ST_HOLD;
            inst_wen = 1'b1;
            if (rresp == RESP_OKAY) begin
              inst_d  = rdata;
              fault_d = FAULT_NONE;
            end else begin
              inst_d  = NOP_INST;
              fault_d = FAULT_ACCESS;
            end
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (flush || inst_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  ysyx_23060191_ifu_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_pc_reg (
    .clk  (clk),
    .rstn (rstn),
    .wen  (pc_wen),
    .din  (pc_in),
    .dout (pc_q)
  );

  ysyx_23060191_ifu_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_inst_reg (
    .clk  (clk),
    .rstn (rstn),
    .wen  (inst_wen),
    .din  (inst_d),
    .dout (inst_q)
  );

  ysyx_23060191_ifu_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_inst_pc_reg (
    .clk  (clk),
    .rstn (rstn),
    .wen  (inst_wen),
    .din  (inst_pc_d),
    .dout (inst_pc_q)
  );

  ysyx_23060191_ifu_reg #(.WIDTH(2), .RESET_VAL(2'b00)) u_fault_reg (
    .clk  (clk),
    .rstn (rstn),
    .wen  (inst_wen),
    .din  (fault_d),
    .dout (fault_q)
  );

endmodule

// File: doc/ysyx_23060191_ifu.md
# ysyx_23060191_ifu

Instruction fetch unit sitting directly downstream of the PC unit and upstream of the decoder (IDU). It accepts a fetch PC over a valid/ready handshake, issues a single read to instruction memory over an AXI-lite-style AR/R channel pair, and presents the fetched instruction, its PC and any fetch fault to the IDU. Only one fetch is outstanding at a time. A flush input discards any in-flight or held fetch on redirect.

## Interface
- CPU_WIDTH, 32: address/data width (shared define).
- NOP_INST, 32'h0000_0013: instruction word substituted on a fault.

- clk  in  1  clock, all state on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- pc_in  in  CPU_WIDTH  fetch address from PCU.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  IFU accepts a PC this cycle.
- flush  in  1  redirect: drop current fetch.
- araddr  out  CPU_WIDTH  read address.
- arvalid  out  1  read address valid.
- arready  in  1  memory accepts the address.
- rdata  in  CPU_WIDTH  read data.
- rresp  in  2  read response, 2'b00 = OKAY.
- rvalid  in  1  read data valid.
- rready  out  1  IFU accepts read data.
- inst  out  CPU_WIDTH  fetched instruction.
- inst_pc  out  CPU_WIDTH  PC of inst.
- inst_fault  out  2  2'b00 none, 2'b01 misaligned, 2'b10 access fault.
- inst_valid  out  1  inst/inst_pc/inst_fault are valid.
- inst_ready  in  1  IDU consumes the instruction.

## Operation
- States: IDLE, REQ, WAIT, HOLD; drop flag `drop_q`.
- IDLE: pc_ready = !flush. On pc_valid && pc_ready: pc_q <= pc_in. If pc_in[1:0] != 0 → HOLD with inst = NOP_INST, fault 2'b01, no bus access. Else → REQ.
- REQ: arvalid = 1, araddr = pc_q, both stable until arready. On arready → WAIT.
- WAIT: rready = 1. On rvalid: if drop_q → IDLE, clear drop_q, data discarded. Else capture inst = (rresp == 0) ? rdata : NOP_INST, fault = (rresp == 0) ? 2'b00 : 2'b10, inst_pc = pc_q → HOLD.
- HOLD: inst_valid = 1, outputs stable. On inst_ready → IDLE.
- flush: IDLE – pc_ready forced 0, nothing else. REQ – arvalid is not withdrawn; drop_q <= 1, the request completes and its response is discarded in WAIT. WAIT – drop_q <= 1, or if rvalid the same cycle the response is discarded and go IDLE. HOLD – go IDLE, inst_valid low next cycle regardless of inst_ready.
- Only rresp 2'b00 counts as success; any other value is an access fault.

## Timing
- Reset values: state IDLE, drop_q 0, inst 0, inst_pc 0, inst_fault 0, inst_valid 0, arvalid 0, rready 0, araddr 0. pc_ready is 1 in the first cycle after reset release when flush = 0.
- Reset mid-operation: immediate IDLE, with all bus and output valids low. The memory slave is reset by the same rstn.
- Zero-wait memory (arready, rvalid in the first possible cycle): PC accepted at cycle N, arvalid at N+1, rvalid sampled at N+2, inst_valid at N+3. Throughput is 1 instruction per 4 cycles with inst_ready held high.
- Misaligned PC: inst_valid at N+1.
- pc_ready, arvalid, rready and inst_valid are decoded from the registered state only; none combinationally depends on pc_valid/arready/rvalid/inst_ready (pc_ready depends on flush only).

## Structure
- Shared defines.v holds: CPU_WIDTH, NOP_INST, fault codes (FAULT_NONE/MISALIGN/ACCESS), state encoding (2 bits).
- No new sub-module. The pc_q and inst holding registers are instantiations of the existing RegTemplate with reset value 0 and write enable from the FSM.

## Test plan
- Zero-wait fetch: pc_in = 0x8000_0000, memory returns 0x0010_0093 OKAY → inst_valid at N+3 with inst 0x0010_0093, inst_pc 0x8000_0000, fault 00.
- Wait states: arready delayed 3 cycles, rvalid delayed 2 → araddr/arvalid stable throughout, and the single inst_valid holds until inst_ready is asserted 4 cycles late.
- Access fault: rresp = 2'b10, rdata 0xDEAD_BEEF → inst 0x0000_0013, fault 10.
- Misaligned: pc_in = 0x8000_0002 → no arvalid, inst_valid at N+1, inst 0x0000_0013, fault 01.
- Flush during REQ and during WAIT: the response arrives and is discarded with no inst_valid, pc_ready returns high. A new pc 0x8000_0100 is then fetched correctly.
- Reset asserted in WAIT and in HOLD → all outputs are reset values next sample, and the next fetch after release is normal.
